// File: rtl/right_shifter32_seq_pkg.sv
// Shared definitions for the sequential right shifter and its decode logic.
package right_shifter32_seq_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_SHAMT_W = 5;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Fill-mode select: zero fill (logical) or sign fill (arithmetic)
  localparam logic MODE_SRL = 1'b0;
  localparam logic MODE_SRA = 1'b1;

  // R-type funct codes for the right-shift family
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  // Control decode helper: fill mode from the funct field
  function automatic logic arith_from_funct(input logic [5:0] funct);
    return ((funct == FUNCT_SRA) || (funct == FUNCT_SRAV)) ? MODE_SRA : MODE_SRL;
  endfunction

endpackage

// File: rtl/right_shifter32_seq_shift_step_right.sv
// Combinational one-position right shift with selectable fill bit.
module shift_step_right
  import right_shifter32_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_sr,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_sr_c
);

  logic w_fill;

  // Sign fill replicates the current MSB; logical fill inserts zero
  always_comb begin
    w_fill = (i_mode == MODE_SRA) ? i_sr[WIDTH-1] : 1'b0;
    o_sr_c = {w_fill, i_sr[WIDTH-1:1]};
  end

endmodule

// File: rtl/right_shifter32_seq.sv
// Sequential right shifter: one bit position per clock, start/done handshake.
module right_shifter32_seq
  import right_shifter32_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out
);

  state_t               r_state;
  logic [WIDTH-1:0]     r_sr;
  logic [SHAMT_W-1:0]   r_cnt;
  logic                 r_mode;
  logic [WIDTH-1:0]     r_out;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [WIDTH-1:0]     w_sr_nxt;
  logic [SHAMT_W-1:0]   w_cnt_nxt;
  logic                 w_mode_nxt;
  logic [WIDTH-1:0]     w_out_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic [WIDTH-1:0]     w_step;

  shift_step_right #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_sr   (r_sr),
    .i_mode (r_mode),
    .o_sr_c (w_step)
  );

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_SRL;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state, counter and result-capture decode
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_out_nxt   = r_out;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_sr_nxt   = in;
          w_cnt_nxt  = shamt;
          w_mode_nxt = arith;
          if (shamt == SHAMT_W'(0)) begin
            w_out_nxt   = in;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        w_sr_nxt  = w_step;
        w_cnt_nxt = r_cnt - SHAMT_W'(1);
        if (r_cnt == SHAMT_W'(1)) begin
          w_out_nxt   = w_step;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  assign busy = r_busy;
  assign done = r_done;
  assign out  = r_out;

endmodule

// File: tb/tb_right_shifter32_seq.sv
// Self-checking bench for right_shifter32_seq: directed cases plus random traffic
// against an edge-counting behavioural model.
module tb_right_shifter32_seq;

  logic        clk;
  logic        rst_n;
  logic        t_start;
  logic [31:0] t_in;
  logic [4:0]  t_shamt;
  logic        t_arith;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  right_shifter32_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (t_start),
    .in    (t_in),
    .shamt (t_shamt),
    .arith (t_arith),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result: sign fill expressed as complement-shift-complement
  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int sh, input bit ar);
    if (ar && v[31]) return ~((~v) >> sh);
    return v >> sh;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: edge counter e; an op accepted at edge k finishes (done visible) after edge k+shamt,
  // and the unit can accept again from edge k+shamt+2 on.
  int          e      = 0;
  bit          m_act  = 1'b0;
  int          m_de   = 0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_last = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  <= 1'b0;
      m_last <= '0;
    end else begin
      e <= e + 1;
      if (t_start && (!m_act || (e + 1) >= m_de + 2)) begin
        m_act  <= 1'b1;
        m_de   <= e + 1 + int'(t_shamt);
        m_res  <= ref_shift(t_in, int'(t_shamt), t_arith);
        m_last <= (m_act && e >= m_de) ? m_res : m_last;
      end
    end
  end

  // Every-cycle comparison of the DUT outputs with the model
  always @(negedge clk) begin
    chk("cyc_busy", 32'(busy), 32'(m_act && e <= m_de));
    chk("cyc_done", 32'(done), 32'(m_act && e == m_de));
    chk("cyc_out",  out, (m_act && e >= m_de) ? m_res : m_last);
  end

  // One directed operation: checks latency, result, and that out holds until done
  task automatic run_op(input string nm, input logic [31:0] a, input int sh, input bit ar,
                        input logic [31:0] exp, input int exp_lat);
    int          lat;
    bit          seen;
    bit          held;
    logic [31:0] prev;
    @(negedge clk);
    prev    = out;
    t_start = 1'b1;
    t_in    = a;
    t_shamt = 5'(sh);
    t_arith = ar;
    @(negedge clk);
    t_start = 1'b0;
    t_in    = $urandom;
    lat     = 1;
    seen    = 1'b0;
    held    = 1'b1;
    while (!seen && lat <= 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (out !== prev) held = 1'b0;
        @(negedge clk);
        lat++;
      end
    end
    chk({nm, "_lat"},  32'(lat), 32'(exp_lat));
    chk({nm, "_out"},  out, exp);
    chk({nm, "_hold"}, 32'(held), 32'd1);
  endtask

  int n_done_rand;

  initial begin
    rst_n   = 1'b0;
    t_start = 1'b0;
    t_in    = '0;
    t_shamt = '0;
    t_arith = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out",  out, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Model pins
    chk("ref_sra_neg31", ref_shift(32'h8000_0000, 31, 1'b1), 32'hFFFF_FFFF);
    chk("ref_srl31",     ref_shift(32'h8000_0000, 31, 1'b0), 32'h0000_0001);
    chk("ref_sra_pos",   ref_shift(32'h7FFF_FFFF, 16, 1'b1), 32'h0000_7FFF);

    run_op("srl4",     32'hF000_0000, 4,  1'b0, 32'h0F00_0000, 5);
    run_op("sra_neg",  32'h8000_0000, 31, 1'b1, 32'hFFFF_FFFF, 32);
    run_op("sra_pos",  32'h7FFF_FFFF, 16, 1'b1, 32'h0000_7FFF, 17);
    run_op("srl31",    32'hFFFF_FFFF, 31, 1'b0, 32'h0000_0001, 32);
    run_op("zero",     32'h1234_5678, 0,  1'b0, 32'h1234_5678, 1);
    @(negedge clk);
    chk("zero_busy_drop", 32'(busy), 32'd0);

    // Start re-asserted while busy (cycle 3) and in the DONE cycle (cycle 9) is ignored
    @(negedge clk);
    t_start = 1'b1; t_in = 32'h0000_FF00; t_shamt = 5'd8; t_arith = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      t_start = (c == 3 || c == 9);
      t_in    = 32'hDEAD_BEEF;
      t_shamt = 5'd4;
      if (c == 9) begin
        chk("rej_done9", 32'(done), 32'd1);
        chk("rej_out9",  out, 32'h0000_00FF);
      end else begin
        chk("rej_nodone", 32'(done), 32'd0);
      end
      if (c >= 10) chk("rej_idle", 32'(busy), 32'd0);
    end
    t_start = 1'b0;
    chk("rej_out_hold", out, 32'h0000_00FF);

    // Back-to-back: second start lands in the cycle right after DONE
    run_op("b2b_a", 32'hA5A5_0000, 3, 1'b0, 32'h14B4_A000, 4);
    run_op("b2b_b", 32'h8000_0010, 2, 1'b1, 32'hE000_0004, 3);

    // Reset in the middle of an operation
    @(negedge clk);
    t_start = 1'b1; t_in = 32'hFFFF_0000; t_shamt = 5'd10; t_arith = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_out",  out, 32'd0);
    repeat (12) begin
      @(negedge clk);
      chk("midrst_nodone", 32'(done), 32'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op("post_rst", 32'h0000_0010, 4, 1'b0, 32'h0000_0001, 5);

    // Random traffic, including starts that arrive while busy
    n_done_rand = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) n_done_rand++;
      t_start = (($urandom % 4) == 0);
      t_in    = $urandom;
      case ($urandom % 8)
        0:       t_shamt = 5'd0;
        1:       t_shamt = 5'd31;
        default: t_shamt = 5'($urandom % 32);
      endcase
      t_arith = 1'($urandom % 2);
    end
    t_start = 1'b0;
    repeat (40) @(negedge clk);
    chk("rand_progress", 32'(n_done_rand > 50), 32'd1);
    chk("rand_idle_end", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
